// File: rtl/branch_exec_unit.sv
// Two-stage conditional-branch execute unit: X0 evaluates the condition and target, X1 presents the completion.
// Optional macro BRANCH_EXEC_MISALIGN_EN adds W_misaligned and suppresses redirects for misaligned taken targets.
module branch_exec_unit #(
    parameter int p_seq_num_bits = 5,
    parameter int p_addr_bits    = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      D_val,
    output logic                      D_rdy,
    input  logic [p_addr_bits-1:0]    D_pc,
    input  logic [31:0]               D_op1,
    input  logic [31:0]               D_op2,
    input  logic [31:0]               D_imm,
    input  logic [2:0]                D_func,
    input  logic [p_seq_num_bits-1:0] D_seq_num,
    input  logic                      sq_in_val,
    input  logic [p_seq_num_bits-1:0] sq_in_seq_num,
`ifdef BRANCH_EXEC_MISALIGN_EN
    output logic                      W_misaligned,
`endif
    output logic                      W_val,
    input  logic                      W_rdy,
    output logic [p_seq_num_bits-1:0] W_seq_num,
    output logic                      W_taken,
    output logic [p_addr_bits-1:0]    W_target,
    output logic                      sq_out_val,
    output logic [p_seq_num_bits-1:0] sq_out_seq_num,
    output logic [p_addr_bits-1:0]    sq_out_target
);
    localparam int SW = p_seq_num_bits;
    localparam int AW = p_addr_bits;
    localparam logic [SW-1:0] SEQ_HALF = SW'(1 << (SW - 1));

    // Age distance in [1, 2^(n-1)-1] means e was issued after r.
    function automatic logic is_younger(input logic [SW-1:0] e, input logic [SW-1:0] r);
        logic [SW-1:0] d;
        d = e - r;
        return (d != '0) && (d < SEQ_HALF);
    endfunction

    function automatic logic br_cond(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic               res;
        sa  = a;
        sb  = b;
        res = 1'b0;
        case (f)
            3'b000:  res = (a == b);
            3'b001:  res = (a != b);
            3'b100:  res = (sa < sb);
            3'b101:  res = (sa >= sb);
            3'b110:  res = (a < b);
            3'b111:  res = (a >= b);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    logic          x0_val_q;
    logic [AW-1:0] x0_pc_q;
    logic [31:0]   x0_op1_q;
    logic [31:0]   x0_op2_q;
    logic [31:0]   x0_imm_q;
    logic [2:0]    x0_func_q;
    logic [SW-1:0] x0_seq_q;

    logic          x1_val_q;
    logic [SW-1:0] x1_seq_q;
    logic          x1_taken_q;
    logic [AW-1:0] x1_target_q;

    logic          sq_val_q;
    logic [SW-1:0] sq_seq_q;
    logic [AW-1:0] sq_tgt_q;

    logic          own_dead, kill_v, x0_live, x1_live, x1_free, move, d_fire, d_keep, w_fire, redirect;
    logic [SW-1:0] kill_seq;
    logic          x0_taken;
    logic [AW-1:0] x0_target;

    // A redirect of our own is never younger than a concurrent external one unless it is itself killed,
    // so when it survives it carries the older squash point.
    assign own_dead   = sq_in_val && is_younger(sq_seq_q, sq_in_seq_num);
    assign sq_out_val = sq_val_q && !own_dead;
    assign kill_v     = sq_in_val || sq_out_val;
    assign kill_seq   = sq_out_val ? sq_seq_q : sq_in_seq_num;

    assign x0_live = x0_val_q && !(kill_v && is_younger(x0_seq_q, kill_seq));
    assign x1_live = x1_val_q && !(kill_v && is_younger(x1_seq_q, kill_seq));
    assign d_keep  = !(kill_v && is_younger(D_seq_num, kill_seq));

    assign W_val   = x1_live;
    assign w_fire  = x1_live && W_rdy;
    assign x1_free = !x1_live || W_rdy;
    assign move    = x0_live && x1_free;
    assign D_rdy   = !rst && (!x0_live || x1_free);
    assign d_fire  = D_val && D_rdy;

    assign x0_taken  = br_cond(x0_func_q, x0_op1_q, x0_op2_q);
    assign x0_target = x0_pc_q + (x0_taken ? x0_imm_q[AW-1:0] : AW'(4));

`ifdef BRANCH_EXEC_MISALIGN_EN
    logic x1_mis_q;
    logic x0_mis;
    assign x0_mis       = x0_taken && (x0_target[1:0] != 2'b00);
    assign W_misaligned = x1_mis_q;
    assign redirect     = w_fire && x1_taken_q && !x1_mis_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x1_mis_q <= 1'b0;
        end else if (move) begin
            x1_mis_q <= x0_mis;
        end
    end
`else
    assign redirect = w_fire && x1_taken_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x0_val_q <= 1'b0;
            x1_val_q <= 1'b0;
            sq_val_q <= 1'b0;
        end else begin
            x0_val_q <= d_fire ? d_keep : (x0_live && !move);
            x1_val_q <= move || (x1_live && !W_rdy);
            sq_val_q <= redirect;
        end
    end

    // X0: operand capture
    always_ff @(posedge clk) begin
        if (d_fire) begin
            x0_pc_q   <= D_pc;
            x0_op1_q  <= D_op1;
            x0_op2_q  <= D_op2;
            x0_imm_q  <= D_imm;
            x0_func_q <= D_func;
            x0_seq_q  <= D_seq_num;
        end
    end

    // X1: resolved branch, and the registered redirect behind it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x1_seq_q    <= '0;
            x1_taken_q  <= 1'b0;
            x1_target_q <= '0;
            sq_seq_q    <= '0;
            sq_tgt_q    <= '0;
        end else begin
            if (move) begin
                x1_seq_q    <= x0_seq_q;
                x1_taken_q  <= x0_taken;
                x1_target_q <= x0_target;
            end
            if (redirect) begin
                sq_seq_q <= x1_seq_q;
                sq_tgt_q <= x1_target_q;
            end
        end
    end

    assign W_seq_num      = x1_seq_q;
    assign W_taken        = x1_taken_q;
    assign W_target       = x1_target_q;
    assign sq_out_seq_num = sq_seq_q;
    assign sq_out_target  = sq_tgt_q;

endmodule

// File: doc/branch_exec_unit.md
Name: branch_exec_unit

Overview:
- Execute-stage functional unit for BlimpV7 conditional branches: BEQ, BNE, BLT, BGE, BLTU, BGEU.
- Accepts issued branch micro-ops from the issue stage.
- Evaluates the condition and computes the target.
- Sends a completion to the writeback/commit stage.
- Sends a one-cycle redirect/squash to fetch and the other pipes when a branch is taken.
- Two-stage, val/rdy on both sides; it is the stage the directed branch suites (bge, etc.) exercise directly.

Parameters:
- p_seq_num_bits, 5: width of the instruction sequence number (age tag, wraps modulo 2^n).
- p_addr_bits, 32: PC/target width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- D_val  in  1  issued branch valid.
- D_rdy  out  1  unit can accept.
- D_pc  in  p_addr_bits  branch PC.
- D_op1  in  32  rs1 value.
- D_op2  in  32  rs2 value.
- D_imm  in  32  sign-extended B-type offset.
- D_func  in  3  RISC-V funct3 (000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu).
- D_seq_num  in  p_seq_num_bits  age tag.
- sq_in_val  in  1  external squash (from an older redirect).
- sq_in_seq_num  in  p_seq_num_bits  seq of the squashing instruction.
- W_val  out  1  completion valid.
- W_rdy  in  1  commit accepts.
- W_seq_num  out  p_seq_num_bits  completed seq.
- W_taken  out  1  branch outcome.
- W_target  out  p_addr_bits  redirect address: taken -> pc+imm, not-taken -> pc+4.
- sq_out_val  out  1  redirect pulse.
- sq_out_seq_num  out  p_seq_num_bits  seq of the redirecting branch.
- sq_out_target  out  p_addr_bits  redirect PC.

Interface (already decided): one clock `clk`; reset `rst` is asynchronous and active-high.

Behaviour:
- Reset: all pipeline valid bits clear. D_rdy=0 while rst high, 1 the cycle after. W_val=0, sq_out_val=0, all data outputs 0.
- X0 (compute) register: captures the D_* fields on D_val&&D_rdy.
  - Comparison: signed for blt/bge; unsigned for bltu/bgeu; eq/ne bitwise.
  - Undefined funct3 (010, 011): not-taken.
- Target arithmetic: modulo 2^p_addr_bits. Carries out are discarded (pc+imm wraps).
- X1 (result) register: loaded from X0 when X1 is empty or is being drained that cycle. Drives W_* directly.
- Latency: accept at cycle N -> W_val at N+2 if W_rdy is held high.
- Throughput: one branch/cycle when W_rdy=1.
- D_rdy: high when X0 is empty, or X0 will move to X1 this cycle (X1 empty or W_val&&W_rdy). Combinational on W_rdy.
- W_val, once asserted, holds W_* stable until W_rdy, unless squashed.
- sq_out_val: pulses for exactly one cycle, registered, on the cycle after a W handshake with W_taken=1. Carries that branch's seq_num and target.
  - Not-taken branches complete without a redirect.
  - Fetch predicts not-taken, so only taken branches redirect.
- External squash: when sq_in_val=1, any valid entry in X0 or X1 whose seq is strictly younger than sq_in_seq_num is invalidated the same cycle.
  - Younger means ((entry - sq) mod 2^n) in [1, 2^(n-1)-1].
  - A W_val entry being squashed does not handshake: W_val is forced low combinationally that cycle.
  - An entry with seq == sq_in_seq_num is kept.
  - An incoming D_val op that cycle is also checked and dropped if younger; D_rdy still reads as accepted.
- Own redirect: the unit's own taken branch also squashes younger entries still in X0, using its sq_out values the following cycle. This is the same path as the external squash, with priority to the older of the two.
- Simultaneous sq_in and own redirect: apply the older squash seq. Own sq_out_val is still emitted if its branch is not itself squashed.
- Reset mid-operation: all in-flight ops are discarded immediately; no sq_out pulse.

Optional Feature:
- Macro: BRANCH_EXEC_MISALIGN_EN.
- With the macro: an extra output W_misaligned (1 bit) is set when the branch is taken and target[1:0]!=0. A misaligned branch completes with W_taken=1 but does not pulse sq_out_val; commit raises the exception.
- Without the macro: the port is absent and the redirect is issued regardless of alignment.

Test Plan:
- bge: pc=0x200, op1=5, op2=5, imm=0x10, W_rdy=1 -> W_val at +2 cycles, W_taken=1, W_target=0x210; sq_out_val pulse next cycle with target 0x210.
- bge signed vs bgeu: op1=0xFFFFFFFF, op2=1 -> bge not-taken, W_target=pc+4, no sq_out; bgeu taken.
- Back-to-back four branches with W_rdy=1 -> one completion per cycle in order, D_rdy never low.
- Backpressure: W_rdy=0 for 5 cycles with 3 ops sent -> X0/X1 full, D_rdy=0, W_* stable; release -> drain in order.
- Squash: X0 holds seq 6, X1 holds seq 3, sq_in seq=4 -> seq 6 dropped, seq 3 completes.
- Wrap-around: p_seq_num_bits=3, entry seq 1 vs sq_in seq 7 -> entry treated as younger and dropped.
- Imm wrap: pc=0x4, imm=0xFFFFFFF8 -> target 0xFFFFFFFC.
- Reset asserted with ops in flight -> W_val=0 and sq_out_val=0 immediately.
